// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART core blocks.
// Build option: UART_TX_PARITY_EN adds the PARITY state to the transmitter FSM.
`timescale 1ns/1ps
package uart_pkg;

    // Every start, data and parity bit spans this many s_tick pulses.
    localparam int OVERSAMPLE = 16;

    // Tick counter width; wide enough for a 2-stop-bit period (SB_TICK = 32).
    localparam int S_W = 5;

    // Bit counter width; covers up to 8 data bits.
    localparam int N_W = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running mod-M counter. max_tick is high for one clk every M
// clks and serves as the 16x-oversampling s_tick for the UART core.
`timescale 1ns/1ps
module baud_gen #(
    parameter int N = 8,
    parameter int M = 163
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam logic [N-1:0] LAST = N'(M - 1);

    logic [N-1:0] r;

    // Count 0..M-1 and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
        end else if (r == LAST) begin
            r <= '0;
        end else begin
            r <= r + 1'b1;
        end
    end

    assign max_tick = (r == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmit engine draining the TX FIFO. Pops one byte per
// frame and sends it LSB-first as start bit, DBIT data bits, optional parity
// bit and a stop period of SB_TICK s_ticks.
// Build option: UART_TX_PARITY_EN adds input par_odd and a parity bit after
// the data bits (par_odd = 0 even parity, 1 odd parity).
`timescale 1ns/1ps
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rd_data,
`ifdef UART_TX_PARITY_EN
    input  logic            par_odd,
`endif
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam logic [S_W-1:0] BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST    = N_W'(DBIT - 1);

    tx_state_t       state;
    logic [S_W-1:0]  s;
    logic [N_W-1:0]  n;
    logic [DBIT-1:0] b;
`ifdef UART_TX_PARITY_EN
    // Untouched copy of the popped byte; b is destroyed by shifting.
    logic [DBIT-1:0] b_copy;
`endif

    // Frame sequencer; every output is registered and tx is loaded with the
    // value of the state being entered so the line never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            s       <= '0;
            n       <= '0;
            // NOTE: the shift register is a handful of flops, not a memory,
            // so it is reset along with the control state.
            b       <= '0;
`ifdef UART_TX_PARITY_EN
            b_copy  <= '0;
`endif
            tx      <= 1'b1;
            fifo_rd <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the values
            // from before this edge; the two strobes default low here and
            // are raised for a single clk by the branches below.
            fifo_rd <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        b       <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        b_copy  <= fifo_rd_data;
`endif
                        s       <= '0;
                        // NOTE: the pop strobe lags the latch by one clk; the
                        // head word is already captured in b and only our
                        // own pop can advance the FIFO head, so nothing is lost.
                        fifo_rd <= 1'b1;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        tx <= 1'b1;
                    end
                end

                ST_START: begin
                    if (s_tick) begin
                        if (s == BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= b[0];
                            state <= ST_DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (s_tick) begin
                        if (s == BIT_LAST) begin
                            s <= '0;
                            b <= b >> 1;
                            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                tx    <= (^b_copy) ^ par_odd;
                                state <= ST_PARITY;
`else
                                tx    <= 1'b1;
                                state <= ST_STOP;
`endif
                            end else begin
                                n  <= n + 1'b1;
                                tx <= b[1];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s == BIT_LAST) begin
                            s     <= '0;
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (s_tick) begin
                        if (s == STOP_LAST) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
